id_ex_ctrl_stage: RTL and testbench
===================================

# id_ex_ctrl_stage

Registered decode stage for the RV64I/Zba pipeline. It fully decodes a 32-bit instruction into datapath controls and holds the result in the ID/EX pipeline register, with a valid/ready handshake on both sides. Beyond plain decode, it detects load-use hazards and inserts bubbles, supports pipeline flush, flags illegal instructions per configured XLEN and Zba mode, and counts stall bubbles.

## Interface
- XLEN, 64, 32 or 64; when 32, all word-op and 64-bit-only encodings are illegal
- ZBA_EN, 1, 0 makes every Zba encoding illegal
- CNT_W, 16, stall counter width
- clk  in  1  clock; rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction from IF/ID
- in_valid  in  1  instr valid
- in_ready  out  1  stage accepts instr this cycle
- flush  in  1  kill ID/EX contents and refuse input this cycle
- out_ready  in  1  EX consumes output this cycle
- out_valid  out  1  ID/EX holds a real instruction
- ResultSrc  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm
- MemWrite, ALUSrc, RegWrite, Branch, Jump  out  1 each  datapath controls
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- ALUControl  out  5  ALU operation code
- rd, rs1, rs2  out  5 each  register fields
- funct3  out  3  instr[14:12] passthrough
- illegal  out  1  unsupported encoding
- stall_count  out  CNT_W  saturating count of load-use bubbles

## Operation
- Full 7-bit opcode decode:
  - LOAD 0000011: RegWrite, ALUSrc, ResultSrc=01, ImmSrc=000.
  - STORE 0100011: MemWrite, ALUSrc, ImmSrc=001.
  - OP 0110011 and OP-IMM 0010011: RegWrite; OP-IMM also sets ALUSrc.
  - OP-32 0111011 and OP-IMM-32 0011011: as OP and OP-IMM, using the word ALU codes.
  - LUI 0110111: RegWrite, ALUSrc, ImmSrc=011, ResultSrc=11.
  - BRANCH 1100011: Branch, ImmSrc=010, ALUControl=SUB.
  - JAL 1101111: Jump, RegWrite, ImmSrc=100, ResultSrc=10.
- ALUControl codes: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, ADDW 01000, SUBW 01001, sh1/2/3add 10000/10001/10010, add.uw 10011, sh1/2/3add.uw 10100/10101/10110.
- LOAD, STORE, LUI and JAL use ADD.
- OP legal encodings:
  - funct7 0000000 with funct3 000/111/110/100 gives ADD/AND/OR/XOR.
  - funct7 0100000 with funct3 000 gives SUB.
  - funct7 0010000 with funct3 010/100/110 gives shNadd.
- OP-IMM legal funct3: 000, 100, 110, 111.
- OP-IMM-32 legal funct3: 000 only (ADDW).
- OP-32 legal encodings:
  - 0000000/000 gives ADDW.
  - 0100000/000 gives SUBW.
  - 0000100/000 gives add.uw.
  - 0010000 with funct3 010/100/110 gives shNadd.uw.
- LOAD funct3 111 is illegal. With XLEN=32, LOAD 011/110 are also illegal.
- BRANCH funct3 010/011 are illegal.
- Any other opcode, or any other encoding not listed above, is illegal.
- An illegal instruction is registered with out_valid=1 and illegal=1. RegWrite, MemWrite, Branch and Jump are all forced to 0.
- rs1 is used by every opcode except LUI and JAL. rs2 is used by OP, OP-32, STORE and BRANCH.
- Load-use hazard occurs when all of the following hold:
  - out_valid=1 and the registered instruction is a LOAD with rd≠0;
  - in_valid=1;
  - the incoming instruction uses a source register equal to that rd.

## Timing
- Reset: all outputs and registered fields are 0, out_valid=0, stall_count=0.
- in_ready is combinational: in_ready = !flush && !hazard && (!out_valid || out_ready). Out of reset it is 1.
- Transfer in: in_valid && in_ready. The decoded instruction appears on the outputs the next cycle with out_valid=1 (1-cycle latency).
- When out_valid && !out_ready and there is no flush, the ID/EX register holds every field stable.
- When the output is consumed (out_ready) and nothing is accepted that cycle, out_valid goes to 0 next cycle. Control fields are then zeroed to form a bubble.
- Hazard with out_ready=1: next cycle out_valid=0 (bubble) and stall_count increments. The dependent instruction is accepted in the following cycle, giving exactly one bubble per load-use.
- Hazard with out_ready=0: hold; no count.
- stall_count saturates at 2^CNT_W-1 and never wraps.
- flush: next cycle out_valid=0 and controls are zeroed. The input is not accepted and no count is taken. flush has priority over hazard and over the hold.
- rst_n assertion mid-operation clears everything immediately. The in-flight instruction is lost.

## Test plan
- Reset, then present ADD x3,x1,x2 (0x002081B3) with out_ready=1 -> next cycle out_valid=1, RegWrite=1, ALUControl=00000, rd=3.
- LD x5,0(x1) followed by ADD x6,x5,x2 -> one cycle with in_ready=0, then a bubble (out_valid=0), then ADD issues; stall_count=1. The same pair with rd=x0 -> no bubble.
- XLEN=32 ADDW (0x002081BB), and ZBA_EN=0 sh2add (0x2020C1B3) -> illegal=1 and RegWrite=0. With XLEN=64 and ZBA_EN=1, ADDW gives ALUControl=01000 and sh2add gives 10001.
- out_ready held 0 for 3 cycles -> outputs stable and in_ready=0; release -> the next instruction is accepted in the same cycle.
- flush asserted while out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the input is not consumed; the instruction is accepted the cycle after flush drops.
- CNT_W=2 with 5 load-use pairs -> stall_count reads 3 and holds.

Source files
------------

// File: rtl/id_ex_ctrl_stage.sv
// id_ex_ctrl_stage
//   Registered decode stage for an RV64I/Zba pipeline. A 32-bit instruction
//   from IF/ID is decoded into datapath controls and captured in the ID/EX
//   pipeline register. Both sides use a valid/ready handshake. The stage
//   also detects load-use hazards and inserts a single bubble for each one.
//   It supports a pipeline flush, flags encodings that are illegal for the
//   configured XLEN/Zba mode, and keeps a saturating count of stall bubbles.
//
// Parameters
//   XLEN    32 or 64; with 32, word ops and 64-bit-only loads/stores are illegal
//   ZBA_EN  0 makes every Zba encoding illegal
//   CNT_W   width of the stall bubble counter
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   instr, in_valid     incoming instruction and its valid
//   in_ready            stage accepts instr this cycle (combinational)
//   flush               kill ID/EX contents and refuse input this cycle
//   out_ready           EX consumes the registered instruction this cycle
//   out_valid           ID/EX holds a real instruction
//   ResultSrc ... Jump  registered datapath controls
//   ImmSrc, ALUControl  immediate format and ALU operation
//   rd, rs1, rs2        registered register fields
//   funct3              registered instr[14:12]
//   illegal             registered instruction is an unsupported encoding
//   stall_count         saturating count of load-use bubbles

module id_ex_ctrl_stage #(
  parameter int XLEN   = 64,
  parameter bit ZBA_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [1:0]       ResultSrc,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic             Branch,
  output logic             Jump,
  output logic [2:0]       ImmSrc,
  output logic [4:0]       ALUControl,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_count
);

  localparam bit IS_RV64 = (XLEN == 64);

  // Major opcodes
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  // funct7 groups
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_SHN  = 7'b0010000;
  localparam logic [6:0] F7_UW   = 7'b0000100;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD      = 5'b00000;
  localparam logic [4:0] ALU_SUB      = 5'b00001;
  localparam logic [4:0] ALU_AND      = 5'b00010;
  localparam logic [4:0] ALU_OR       = 5'b00011;
  localparam logic [4:0] ALU_XOR      = 5'b00100;
  localparam logic [4:0] ALU_ADDW     = 5'b01000;
  localparam logic [4:0] ALU_SUBW     = 5'b01001;
  localparam logic [4:0] ALU_SH1ADD   = 5'b10000;
  localparam logic [4:0] ALU_SH2ADD   = 5'b10001;
  localparam logic [4:0] ALU_SH3ADD   = 5'b10010;
  localparam logic [4:0] ALU_ADDUW    = 5'b10011;
  localparam logic [4:0] ALU_SH1ADDUW = 5'b10100;
  localparam logic [4:0] ALU_SH2ADDUW = 5'b10101;
  localparam logic [4:0] ALU_SH3ADDUW = 5'b10110;

  // Result mux and immediate format selects
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef struct packed {
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic [2:0] imm_src;
    logic [4:0] alu_control;
    logic       illegal;
  } ctrl_t;

  // Incoming instruction fields
  logic [6:0] in_opcode;
  logic [2:0] in_funct3;
  logic [6:0] in_funct7;
  logic [4:0] in_rd;
  logic [4:0] in_rs1;
  logic [4:0] in_rs2;

  assign in_opcode = instr[6:0];
  assign in_rd     = instr[11:7];
  assign in_funct3 = instr[14:12];
  assign in_rs1    = instr[19:15];
  assign in_rs2    = instr[24:20];
  assign in_funct7 = instr[31:25];

  ctrl_t dec_raw;
  ctrl_t dec;
  logic  dec_legal;

  // ID/EX pipeline register contents
  ctrl_t           ex_ctrl;
  logic [4:0]      ex_rd;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [2:0]      ex_funct3;
  logic            ex_is_load;
  logic            out_valid_q;
  logic [CNT_W-1:0] stall_count_q;

  logic uses_rs1;
  logic uses_rs2;
  logic hazard;
  logic accept;
  logic stall_event;

  // Opcode/funct decode. dec_legal starts low so that anything not matched
  // below (unknown opcode or unlisted funct combination) comes out illegal.
  always_comb begin
    dec_raw             = '0;
    dec_raw.alu_control = ALU_ADD;
    dec_legal           = 1'b0;
    case (in_opcode)
      OPC_LOAD: begin
        dec_raw.reg_write  = 1'b1;
        dec_raw.alu_src    = 1'b1;
        dec_raw.result_src = RES_MEM;
        dec_raw.imm_src    = IMM_I;
        // LD and LWU only exist on RV64
        dec_legal = (in_funct3 != 3'b111) &&
                    (IS_RV64 || ((in_funct3 != 3'b011) && (in_funct3 != 3'b110)));
      end
      OPC_STORE: begin
        dec_raw.mem_write = 1'b1;
        dec_raw.alu_src   = 1'b1;
        dec_raw.imm_src   = IMM_S;
        // SB/SH/SW always, SD only on RV64
        dec_legal = (in_funct3 < 3'b011) || (IS_RV64 && (in_funct3 == 3'b011));
      end
      OPC_OP: begin
        dec_raw.reg_write = 1'b1;
        case ({in_funct7, in_funct3})
          {F7_BASE, 3'b000}: begin dec_raw.alu_control = ALU_ADD; dec_legal = 1'b1; end
          {F7_BASE, 3'b111}: begin dec_raw.alu_control = ALU_AND; dec_legal = 1'b1; end
          {F7_BASE, 3'b110}: begin dec_raw.alu_control = ALU_OR;  dec_legal = 1'b1; end
          {F7_BASE, 3'b100}: begin dec_raw.alu_control = ALU_XOR; dec_legal = 1'b1; end
          {F7_ALT,  3'b000}: begin dec_raw.alu_control = ALU_SUB; dec_legal = 1'b1; end
          {F7_SHN,  3'b010}: begin dec_raw.alu_control = ALU_SH1ADD; dec_legal = ZBA_EN; end
          {F7_SHN,  3'b100}: begin dec_raw.alu_control = ALU_SH2ADD; dec_legal = ZBA_EN; end
          {F7_SHN,  3'b110}: begin dec_raw.alu_control = ALU_SH3ADD; dec_legal = ZBA_EN; end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec_raw.reg_write = 1'b1;
        dec_raw.alu_src   = 1'b1;
        dec_raw.imm_src   = IMM_I;
        case (in_funct3)
          3'b000: begin dec_raw.alu_control = ALU_ADD; dec_legal = 1'b1; end
          3'b100: begin dec_raw.alu_control = ALU_XOR; dec_legal = 1'b1; end
          3'b110: begin dec_raw.alu_control = ALU_OR;  dec_legal = 1'b1; end
          3'b111: begin dec_raw.alu_control = ALU_AND; dec_legal = 1'b1; end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_OP_32: begin
        dec_raw.reg_write = 1'b1;
        case ({in_funct7, in_funct3})
          {F7_BASE, 3'b000}: begin dec_raw.alu_control = ALU_ADDW;     dec_legal = IS_RV64; end
          {F7_ALT,  3'b000}: begin dec_raw.alu_control = ALU_SUBW;     dec_legal = IS_RV64; end
          {F7_UW,   3'b000}: begin dec_raw.alu_control = ALU_ADDUW;    dec_legal = IS_RV64 && ZBA_EN; end
          {F7_SHN,  3'b010}: begin dec_raw.alu_control = ALU_SH1ADDUW; dec_legal = IS_RV64 && ZBA_EN; end
          {F7_SHN,  3'b100}: begin dec_raw.alu_control = ALU_SH2ADDUW; dec_legal = IS_RV64 && ZBA_EN; end
          {F7_SHN,  3'b110}: begin dec_raw.alu_control = ALU_SH3ADDUW; dec_legal = IS_RV64 && ZBA_EN; end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM_32: begin
        dec_raw.reg_write   = 1'b1;
        dec_raw.alu_src     = 1'b1;
        dec_raw.imm_src     = IMM_I;
        dec_raw.alu_control = ALU_ADDW;
        dec_legal = IS_RV64 && (in_funct3 == 3'b000);
      end
      OPC_LUI: begin
        dec_raw.reg_write  = 1'b1;
        dec_raw.alu_src    = 1'b1;
        dec_raw.imm_src    = IMM_U;
        dec_raw.result_src = RES_IMM;
        dec_legal = 1'b1;
      end
      OPC_BRANCH: begin
        dec_raw.branch      = 1'b1;
        dec_raw.imm_src     = IMM_B;
        dec_raw.alu_control = ALU_SUB;
        dec_legal = (in_funct3 != 3'b010) && (in_funct3 != 3'b011);
      end
      OPC_JAL: begin
        dec_raw.jump       = 1'b1;
        dec_raw.reg_write  = 1'b1;
        dec_raw.imm_src    = IMM_J;
        dec_raw.result_src = RES_PC4;
        dec_legal = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // An illegal instruction still flows down the pipe so EX can trap on it,
  // but it must not write state or redirect the PC.
  always_comb begin
    dec         = dec_raw;
    dec.illegal = !dec_legal;
    if (!dec_legal) begin
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
  end

  // Source-register usage is by opcode alone, so even an illegal or unknown
  // opcode is treated as reading rs1 (conservative).
  always_comb begin
    uses_rs1 = (in_opcode != OPC_LUI) && (in_opcode != OPC_JAL);
    uses_rs2 = (in_opcode == OPC_OP)    || (in_opcode == OPC_OP_32) ||
               (in_opcode == OPC_STORE) || (in_opcode == OPC_BRANCH);
  end

  // Load-use: the load sitting in ID/EX produces its data one cycle too late
  // for a dependent instruction entering EX right behind it.
  always_comb begin
    hazard = out_valid_q && ex_is_load && (ex_rd != 5'd0) && in_valid &&
             ((uses_rs1 && (in_rs1 == ex_rd)) || (uses_rs2 && (in_rs2 == ex_rd)));
    in_ready    = !flush && !hazard && (!out_valid_q || out_ready);
    accept      = in_valid && in_ready;
    stall_event = hazard && out_ready && !flush;
  end

  // ID/EX register. Priority: flush, then a new transfer, then hold while EX
  // stalls; otherwise the slot drains into a zeroed bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ex_ctrl     <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_funct3   <= '0;
      ex_is_load  <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      ex_ctrl     <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_funct3   <= '0;
      ex_is_load  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      ex_ctrl     <= dec;
      ex_rd       <= in_rd;
      ex_rs1      <= in_rs1;
      ex_rs2      <= in_rs2;
      ex_funct3   <= in_funct3;
      ex_is_load  <= (in_opcode == OPC_LOAD);
    end else if (!(out_valid_q && !out_ready)) begin
      out_valid_q <= 1'b0;
      ex_ctrl     <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_funct3   <= '0;
      ex_is_load  <= 1'b0;
    end
  end

  // Bubble counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (stall_event && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign out_valid   = out_valid_q;
  assign ResultSrc   = ex_ctrl.result_src;
  assign MemWrite    = ex_ctrl.mem_write;
  assign ALUSrc      = ex_ctrl.alu_src;
  assign RegWrite    = ex_ctrl.reg_write;
  assign Branch      = ex_ctrl.branch;
  assign Jump        = ex_ctrl.jump;
  assign ImmSrc      = ex_ctrl.imm_src;
  assign ALUControl  = ex_ctrl.alu_control;
  assign illegal     = ex_ctrl.illegal;
  assign rd          = ex_rd;
  assign rs1         = ex_rs1;
  assign rs2         = ex_rs2;
  assign funct3      = ex_funct3;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// tb_id_ex_ctrl_stage
//   Drives two instances from one stimulus stream: dut_a (XLEN=64, Zba on,
//   16-bit counter) and dut_b (XLEN=32, Zba off, 2-bit counter). A
//   transaction-level model tracks what the ID/EX slot should hold and
//   derives every expected output from the instruction-set rules.

module tb_id_ex_ctrl_stage;

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_OP        = 7'b0110011;
  localparam logic [6:0] OP_OPIMM     = 7'b0010011;
  localparam logic [6:0] OP_OP32      = 7'b0111011;
  localparam logic [6:0] OP_OPIMM32   = 7'b0011011;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;

  localparam logic [31:0] I_ADD3   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_LD5    = 32'h0000B283; // ld   x5,0(x1)
  localparam logic [31:0] I_LW5    = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD6   = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] I_LD0    = 32'h0000B003; // ld   x0,0(x1)
  localparam logic [31:0] I_ADD6Z  = 32'h00200333; // add  x6,x0,x2
  localparam logic [31:0] I_ADDW   = 32'h002081BB; // addw x3,x1,x2
  localparam logic [31:0] I_SH2ADD = 32'h2020C1B3; // sh2add x3,x1,x2
  localparam logic [31:0] I_XOR7   = 32'h0020C3B3; // xor  x7,x1,x2

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  // ctl = {ResultSrc, MemWrite, ALUSrc, RegWrite, Branch, Jump, ImmSrc, ALUControl}
  // fld = {rd, rs1, rs2, funct3}
  wire        in_ready_a, out_valid_a, illegal_a;
  wire [14:0] ctl_a;
  wire [17:0] fld_a;
  wire [15:0] cnt_a;
  wire        in_ready_b, out_valid_b, illegal_b;
  wire [14:0] ctl_b;
  wire [17:0] fld_b;
  wire [1:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  bit          m_valid;
  logic [31:0] m_instr;
  int          m_cnt_a;
  int          m_cnt_b;
  logic        last_rdy_a;
  logic        last_rdy_b;

  always #5 clk = ~clk;

  id_ex_ctrl_stage #(.XLEN(64), .ZBA_EN(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid),
    .in_ready(in_ready_a), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid_a), .ResultSrc(ctl_a[14:13]), .MemWrite(ctl_a[12]),
    .ALUSrc(ctl_a[11]), .RegWrite(ctl_a[10]), .Branch(ctl_a[9]), .Jump(ctl_a[8]),
    .ImmSrc(ctl_a[7:5]), .ALUControl(ctl_a[4:0]), .rd(fld_a[17:13]),
    .rs1(fld_a[12:8]), .rs2(fld_a[7:3]), .funct3(fld_a[2:0]),
    .illegal(illegal_a), .stall_count(cnt_a)
  );

  id_ex_ctrl_stage #(.XLEN(32), .ZBA_EN(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid),
    .in_ready(in_ready_b), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid_b), .ResultSrc(ctl_b[14:13]), .MemWrite(ctl_b[12]),
    .ALUSrc(ctl_b[11]), .RegWrite(ctl_b[10]), .Branch(ctl_b[9]), .Jump(ctl_b[8]),
    .ImmSrc(ctl_b[7:5]), .ALUControl(ctl_b[4:0]), .rd(fld_b[17:13]),
    .rs1(fld_b[12:8]), .rs2(fld_b[7:3]), .funct3(fld_b[2:0]),
    .illegal(illegal_b), .stall_count(cnt_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected controls straight from the instruction-set table.
  function automatic void model_decode(input logic [31:0] ins, input bit rv64, input bit zba,
                                       output logic [14:0] ctl, output logic ill);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    logic [1:0] rsel;
    bit mw, as, rw, br, jp;
    logic [2:0] imm;
    logic [4:0] alu;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    rsel = 2'd0; mw = 0; as = 0; rw = 0; br = 0; jp = 0; imm = 3'd0; alu = 5'd0; ok = 0;
    case (op)
      OP_LOAD: begin
        rw = 1; as = 1; rsel = 2'd1; imm = 3'd0;
        ok = (f3 != 3'd7) && (rv64 || (f3 != 3'd3 && f3 != 3'd6));
      end
      OP_STORE: begin
        mw = 1; as = 1; imm = 3'd1;
        ok = (f3 < 3'd3) || (rv64 && f3 == 3'd3);
      end
      OP_OP, OP_OPIMM: begin
        rw = 1;
        if (op == OP_OPIMM) as = 1;
        if ((op == OP_OPIMM || f7 == 7'd0) && (f3 inside {3'd0, 3'd4, 3'd6, 3'd7})) begin
          ok = 1;
          alu = (f3 == 3'd0) ? 5'd0 : (f3 == 3'd7) ? 5'd2 : (f3 == 3'd6) ? 5'd3 : 5'd4;
        end else if (op == OP_OP && f7 == 7'h20 && f3 == 3'd0) begin
          ok = 1; alu = 5'd1;
        end else if (op == OP_OP && zba && f7 == 7'h10 && (f3 inside {3'd2, 3'd4, 3'd6})) begin
          ok = 1; alu = 5'(15 + f3 / 2);
        end
      end
      OP_OP32: begin
        rw = 1;
        if (rv64) begin
          if (f7 == 7'h00 && f3 == 3'd0) begin ok = 1; alu = 5'd8; end
          else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1; alu = 5'd9; end
          else if (zba && f7 == 7'h04 && f3 == 3'd0) begin ok = 1; alu = 5'd19; end
          else if (zba && f7 == 7'h10 && (f3 inside {3'd2, 3'd4, 3'd6})) begin
            ok = 1; alu = 5'(19 + f3 / 2);
          end
        end
      end
      OP_OPIMM32: begin
        rw = 1; as = 1; alu = 5'd8;
        ok = rv64 && f3 == 3'd0;
      end
      OP_LUI: begin rw = 1; as = 1; imm = 3'd3; rsel = 2'd3; ok = 1; end
      OP_BRANCH: begin
        br = 1; imm = 3'd2; alu = 5'd1;
        ok = !(f3 inside {3'd2, 3'd3});
      end
      OP_JAL: begin jp = 1; rw = 1; imm = 3'd4; rsel = 2'd2; ok = 1; end
      default: ok = 0;
    endcase
    ill = !ok;
    if (!ok) begin rw = 0; mw = 0; br = 0; jp = 0; end
    ctl = {rsel, mw, as, rw, br, jp, imm, alu};
  endfunction

  task automatic checkState();
    logic [14:0] ec;
    logic        ei;
    logic [17:0] ef;
    checkOutput("out_valid_a", out_valid_a, m_valid);
    checkOutput("out_valid_b", out_valid_b, m_valid);
    checkOutput("stall_count_a", cnt_a, m_cnt_a);
    checkOutput("stall_count_b", cnt_b, m_cnt_b);
    if (m_valid) begin
      ef = {m_instr[11:7], m_instr[19:15], m_instr[24:20], m_instr[14:12]};
      checkOutput("fields_a", fld_a, ef);
      checkOutput("fields_b", fld_b, ef);
      model_decode(m_instr, 1'b1, 1'b1, ec, ei);
      checkOutput("illegal_a", illegal_a, ei);
      if (ei) checkOutput("forced_zero_a", {ctl_a[12], ctl_a[10], ctl_a[9], ctl_a[8]}, 0);
      else    checkOutput("ctl_a", ctl_a, ec);
      model_decode(m_instr, 1'b0, 1'b0, ec, ei);
      checkOutput("illegal_b", illegal_b, ei);
      if (ei) checkOutput("forced_zero_b", {ctl_b[12], ctl_b[10], ctl_b[9], ctl_b[8]}, 0);
      else    checkOutput("ctl_b", ctl_b, ec);
    end else begin
      checkOutput("bubble_ctl_a", ctl_a, 0);
      checkOutput("bubble_ctl_b", ctl_b, 0);
    end
  endtask

  // One clock cycle: check the registered state, drive inputs, check the
  // combinational in_ready, then advance the model across the edge.
  // Called and returns at a falling edge.
  task automatic applyStimulus(input logic [31:0] ins, input bit iv, input bit ordy, input bit fl);
    bit u1, u2, hz, rdy;
    logic [4:0] lrd;
    checkState();
    instr = ins; in_valid = iv; out_ready = ordy; flush = fl;
    #1;
    lrd = m_instr[11:7];
    u1  = (ins[6:0] != OP_LUI) && (ins[6:0] != OP_JAL);
    u2  = ins[6:0] inside {OP_OP, OP_OP32, OP_STORE, OP_BRANCH};
    hz  = m_valid && (m_instr[6:0] == OP_LOAD) && (lrd != 5'd0) && iv &&
          ((u1 && ins[19:15] == lrd) || (u2 && ins[24:20] == lrd));
    rdy = !fl && !hz && (!m_valid || ordy);
    last_rdy_a = in_ready_a;
    last_rdy_b = in_ready_b;
    checkOutput("in_ready_a", in_ready_a, rdy);
    checkOutput("in_ready_b", in_ready_b, rdy);
    @(posedge clk);
    if (!fl && hz && ordy) begin
      if (m_cnt_a < 65535) m_cnt_a++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
    if (fl) m_valid = 0;
    else if (iv && rdy) begin m_valid = 1; m_instr = ins; end
    else if (!(m_valid && !ordy)) m_valid = 0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] rd_r, rs1_r, rs2_r;
    case ($urandom_range(0, 13))
      0, 1, 2: op = OP_LOAD;
      3:       op = OP_STORE;
      4, 5:    op = OP_OP;
      6:       op = OP_OPIMM;
      7:       op = OP_OP32;
      8:       op = OP_OPIMM32;
      9:       op = OP_LUI;
      10:      op = OP_BRANCH;
      11:      op = OP_JAL;
      12:      op = 7'b0001111;
      default: op = 7'($urandom);
    endcase
    case ($urandom_range(0, 4))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h10;
      3: f7 = 7'h04;
      default: f7 = 7'($urandom);
    endcase
    f3    = 3'($urandom_range(0, 7));
    rd_r  = 5'($urandom_range(0, 3));
    rs1_r = 5'($urandom_range(0, 3));
    rs2_r = 5'($urandom_range(0, 3));
    return {f7, rs2_r, rs1_r, f3, rd_r, op};
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    m_valid = 0; m_instr = '0; m_cnt_a = 0; m_cnt_b = 0;
    last_rdy_a = 0; last_rdy_b = 0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", out_valid_a, 0);
    checkOutput("rst_stall_count", cnt_a, 0);
    checkOutput("rst_ctl", ctl_a, 0);
    checkOutput("rst_fields", fld_a, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", in_ready_a, 1);
    @(negedge clk);

    // Basic ADD
    applyStimulus(I_ADD3, 1, 1, 0);
    checkOutput("add_valid", out_valid_a, 1);
    checkOutput("add_regwrite", ctl_a[10], 1);
    checkOutput("add_aluctl", ctl_a[4:0], 5'b00000);
    checkOutput("add_rd", fld_a[17:13], 3);

    // Load-use pair: one refused cycle, one bubble, then the ADD issues
    applyStimulus(I_LD5, 1, 1, 0);
    applyStimulus(I_ADD6, 1, 1, 0);
    checkOutput("ldu_stall_ready", last_rdy_a, 0);
    checkOutput("ldu_bubble", out_valid_a, 0);
    checkOutput("ldu_count", cnt_a, 1);
    applyStimulus(I_ADD6, 1, 1, 0);
    checkOutput("ldu_issue_ready", last_rdy_a, 1);
    checkOutput("ldu_issue_rd", fld_a[17:13], 6);

    // Same pair with rd=x0: no bubble
    applyStimulus(I_LD0, 1, 1, 0);
    applyStimulus(I_ADD6Z, 1, 1, 0);
    checkOutput("ldx0_ready", last_rdy_a, 1);
    checkOutput("ldx0_valid", out_valid_a, 1);
    checkOutput("ldx0_count", cnt_a, 1);

    // Word op and Zba legality per configuration
    applyStimulus(I_ADDW, 1, 1, 0);
    checkOutput("addw_alu_a", ctl_a[4:0], 5'b01000);
    checkOutput("addw_illegal_a", illegal_a, 0);
    checkOutput("addw_illegal_b", illegal_b, 1);
    checkOutput("addw_regwrite_b", ctl_b[10], 0);
    applyStimulus(I_SH2ADD, 1, 1, 0);
    checkOutput("sh2add_alu_a", ctl_a[4:0], 5'b10001);
    checkOutput("sh2add_illegal_b", illegal_b, 1);
    checkOutput("sh2add_regwrite_b", ctl_b[10], 0);

    // EX stall for three cycles: hold, then accept on release
    for (int i = 0; i < 3; i++) begin
      applyStimulus(I_XOR7, 1, 0, 0);
      checkOutput("hold_ready", last_rdy_a, 0);
      checkOutput("hold_rd", fld_a[17:13], 3);
      checkOutput("hold_alu", ctl_a[4:0], 5'b10001);
    end
    applyStimulus(I_XOR7, 1, 1, 0);
    checkOutput("release_ready", last_rdy_a, 1);
    checkOutput("release_rd", fld_a[17:13], 7);
    checkOutput("release_alu", ctl_a[4:0], 5'b00100);

    // Flush kills the slot and refuses input
    applyStimulus(I_ADD3, 1, 1, 1);
    checkOutput("flush_ready", last_rdy_a, 0);
    checkOutput("flush_valid", out_valid_a, 0);
    applyStimulus(I_ADD3, 1, 1, 0);
    checkOutput("post_flush_ready", last_rdy_a, 1);
    checkOutput("post_flush_rd", fld_a[17:13], 3);

    // Five more load-use pairs saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      applyStimulus(I_LW5, 1, 1, 0);
      applyStimulus(I_ADD6, 1, 1, 0);
      applyStimulus(I_ADD6, 1, 1, 0);
    end
    checkOutput("sat_count_b", cnt_b, 3);
    checkOutput("sat_count_a", cnt_a, 6);

    // Asynchronous reset in the middle of operation
    applyStimulus(I_ADD3, 1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", out_valid_a, 0);
    checkOutput("midrst_count_a", cnt_a, 0);
    checkOutput("midrst_count_b", cnt_b, 0);
    checkOutput("midrst_ctl", ctl_a, 0);
    m_valid = 0; m_cnt_a = 0; m_cnt_b = 0;
    in_valid = 0; flush = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(rand_instr(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) == 0));
    end
    checkState();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
